// File: rtl/adma_dm_axi_ar_sched_if.sv
// adma_dm_axi_ar_sched_if
//   Bundles every non-clock/reset signal of the AR scheduler:
//   - channel request port   : req_vld/req_rdy/req_addr/req_len/chn_arid
//   - AXI AR channel         : m_ar*
//   - R-handler txn port     : atx_chn_id/atx_arid/atx_arlen/atx_vld/atx_rdy
//   - R-handler completion   : rdone_vld/rdone_chn_id
//   - status                 : ostd_cnt
//   modport master : the scheduler (drives AR, txn info, grants)
//   modport slave  : the environment (channels, interconnect, R handler)
interface adma_dm_axi_ar_sched_if #(
  parameter int DMA_CHN_NUM  = 4,
  parameter int MST_ID_W     = 5,
  parameter int ADDR_W       = 32,
  parameter int ATX_LEN_W    = 8,
  parameter int ATX_SIZE_W   = 3,
  parameter int ATX_NUM_OSTD = DMA_CHN_NUM
);
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;
  localparam int OSTD_W        = $clog2(ATX_NUM_OSTD + 1);

  logic [DMA_CHN_NUM-1:0]           req_vld;
  logic [DMA_CHN_NUM-1:0]           req_rdy;
  logic [DMA_CHN_NUM*ADDR_W-1:0]    req_addr;
  logic [DMA_CHN_NUM*ATX_LEN_W-1:0] req_len;
  logic [DMA_CHN_NUM*MST_ID_W-1:0]  chn_arid;

  logic [MST_ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0]     m_araddr;
  logic [ATX_LEN_W-1:0]  m_arlen;
  logic [ATX_SIZE_W-1:0] m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;

  logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
  logic [MST_ID_W-1:0]      atx_arid;
  logic [ATX_LEN_W-1:0]     atx_arlen;
  logic                     atx_vld;
  logic                     atx_rdy;

  logic                     rdone_vld;
  logic [DMA_CHN_NUM_W-1:0] rdone_chn_id;

  logic [OSTD_W-1:0] ostd_cnt;

  modport master (
    input  req_vld, req_addr, req_len, chn_arid, m_arready, atx_rdy,
           rdone_vld, rdone_chn_id,
    output req_rdy, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
           m_arvalid, atx_chn_id, atx_arid, atx_arlen, atx_vld, ostd_cnt
  );

  modport slave (
    output req_vld, req_addr, req_len, chn_arid, m_arready, atx_rdy,
           rdone_vld, rdone_chn_id,
    input  req_rdy, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
           m_arvalid, atx_chn_id, atx_arid, atx_arlen, atx_vld, ostd_cnt
  );
endinterface

// File: rtl/adma_dm_axi_ar_sched.sv
// adma_dm_axi_ar_sched
//   Read-side AR scheduler of the AXI DMA datamover. Round-robin arbitrates
//   per-channel read-burst requests, issues them on the AXI AR channel and
//   hands {chn_id, arid, arlen} of each burst to the R handler. Tracks
//   outstanding bursts globally and per channel; the R handler frees a slot
//   through rdone_vld when the last beat of a burst is accepted.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : adma_dm_axi_ar_sched_if.master (requests, AR, txn info,
//            completion, ostd_cnt)
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | arbitrating; grants one eligible channel and latches its burst
//   ISSUE | AR and txn-info valids held until both handshakes have completed
module adma_dm_axi_ar_sched #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int MST_ID_W       = 5,
  parameter int ADDR_W         = 32,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_SIZE_W     = 3,
  parameter int ATX_SRC_DATA_W = 256,
  parameter int ATX_NUM_OSTD   = DMA_CHN_NUM,
  parameter int CHN_NUM_OSTD   = 2
) (
  input logic                   clk,
  input logic                   rst,
  adma_dm_axi_ar_sched_if.master bus
);
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;
  localparam int OSTD_W        = $clog2(ATX_NUM_OSTD + 1);
  localparam int CHN_CNT_W     = $clog2(CHN_NUM_OSTD + 1);
  localparam logic [ATX_SIZE_W-1:0] AR_SIZE = ATX_SIZE_W'($clog2(ATX_SRC_DATA_W / 8));

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                   state_q;
  logic [DMA_CHN_NUM_W-1:0] ptr_q;
  logic [CHN_CNT_W-1:0]     chn_cnt_q [DMA_CHN_NUM];
  logic [OSTD_W-1:0]        ostd_q;
  logic [ADDR_W-1:0]        araddr_q;
  logic [ATX_LEN_W-1:0]     arlen_q;
  logic [MST_ID_W-1:0]      arid_q;
  logic [DMA_CHN_NUM_W-1:0] chn_q;
  logic                     arvalid_q;
  logic                     atxvld_q;

  logic [DMA_CHN_NUM-1:0]   elig;
  logic [DMA_CHN_NUM-1:0]   chn_inc;
  logic [DMA_CHN_NUM-1:0]   chn_dec;
  logic [DMA_CHN_NUM-1:0]   req_rdy_c;
  logic [DMA_CHN_NUM_W-1:0] cand_idx;
  logic [DMA_CHN_NUM_W-1:0] gnt_idx;
  logic                     gnt_any;
  logic                     gnt_fire;
  logic                     ostd_dec;
  logic                     ar_done;
  logic                     atx_done;
  logic                     rdone_zero;

  // Limits use the registered counts: a same-cycle completion only opens a
  // slot from the following cycle on.
  always_comb begin
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      elig[i] = bus.req_vld[i]
                && (chn_cnt_q[i] < CHN_CNT_W'(CHN_NUM_OSTD))
                && (ostd_q < OSTD_W'(ATX_NUM_OSTD));
    end
  end

  // Search from ptr+1 upward with wrap. Walking k downward lets the closest
  // candidate overwrite farther ones.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int k = DMA_CHN_NUM; k >= 1; k--) begin
      cand_idx = DMA_CHN_NUM_W'((int'(ptr_q) + k) % DMA_CHN_NUM);
      if (elig[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign gnt_fire = (state_q == IDLE) && gnt_any && !rst;

  always_comb begin
    req_rdy_c = '0;
    if (gnt_fire) req_rdy_c[gnt_idx] = 1'b1;
  end

  // A completion against an empty channel counter is dropped, so the global
  // counter can never go below the sum of the per-channel ones.
  always_comb begin
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      chn_inc[i] = gnt_fire && (gnt_idx == DMA_CHN_NUM_W'(i));
      chn_dec[i] = bus.rdone_vld && (bus.rdone_chn_id == DMA_CHN_NUM_W'(i))
                   && (chn_cnt_q[i] != '0);
    end
  end

  assign ostd_dec   = |chn_dec;
  assign rdone_zero = bus.rdone_vld && !ostd_dec;
  assign ar_done    = !arvalid_q || bus.m_arready;
  assign atx_done   = !atxvld_q || bus.atx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= DMA_CHN_NUM_W'(DMA_CHN_NUM - 1);
      ostd_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      chn_q     <= '0;
      arvalid_q <= 1'b0;
      atxvld_q  <= 1'b0;
      for (int i = 0; i < DMA_CHN_NUM; i++) chn_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
        case ({chn_inc[i], chn_dec[i]})
          2'b10:   chn_cnt_q[i] <= chn_cnt_q[i] + CHN_CNT_W'(1);
          2'b01:   chn_cnt_q[i] <= chn_cnt_q[i] - CHN_CNT_W'(1);
          default: chn_cnt_q[i] <= chn_cnt_q[i];
        endcase
      end
      case ({gnt_fire, ostd_dec})
        2'b10:   ostd_q <= ostd_q + OSTD_W'(1);
        2'b01:   ostd_q <= ostd_q - OSTD_W'(1);
        default: ostd_q <= ostd_q;
      endcase

      case (state_q)
        IDLE: begin
          if (gnt_fire) begin
            ptr_q     <= gnt_idx;
            chn_q     <= gnt_idx;
            araddr_q  <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            arlen_q   <= bus.req_len[gnt_idx*ATX_LEN_W +: ATX_LEN_W];
            arid_q    <= bus.chn_arid[gnt_idx*MST_ID_W +: MST_ID_W];
            arvalid_q <= 1'b1;
            atxvld_q  <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (arvalid_q && bus.m_arready) arvalid_q <= 1'b0;
          if (atxvld_q && bus.atx_rdy) atxvld_q <= 1'b0;
          if (ar_done && atx_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy    = req_rdy_c;
  assign bus.m_arid     = arid_q;
  assign bus.m_araddr   = araddr_q;
  assign bus.m_arlen    = arlen_q;
  assign bus.m_arsize   = AR_SIZE;
  assign bus.m_arburst  = 2'b01;
  assign bus.m_arvalid  = arvalid_q;
  assign bus.atx_chn_id = chn_q;
  assign bus.atx_arid   = arid_q;
  assign bus.atx_arlen  = arlen_q;
  assign bus.atx_vld    = atxvld_q;
  assign bus.ostd_cnt   = ostd_q;

  // Simulation-only: a completion with nothing outstanding on that channel
  // points at an R-handler bookkeeping bug.
  a_rdone_has_ostd: assert property (@(posedge clk) disable iff (rst) !rdone_zero);

endmodule

// File: tb/tb_adma_dm_axi_ar_sched.sv
module tb_adma_dm_axi_ar_sched;
  localparam int N   = 4;
  localparam int IDW = 5;
  localparam int AW  = 32;
  localparam int LW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adma_dm_axi_ar_sched_if bus ();

  adma_dm_axi_ar_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Fixed per-channel burst descriptors driven on the request buses.
  logic [AW-1:0]  ch_addr [N] = '{32'h0000_0800, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  logic [LW-1:0]  ch_len  [N] = '{8'd3, 8'd7, 8'd15, 8'd0};
  logic [IDW-1:0] ch_id   [N] = '{5'h10, 5'h03, 5'h07, 5'h1F};

  typedef struct {
    int             chn;
    logic [IDW-1:0] id;
    logic [LW-1:0]  len;
    logic [AW-1:0]  addr;
  } txn_t;

  txn_t ar_q[$];
  txn_t atx_q[$];
  txn_t mon_ar;
  txn_t mon_atx;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic expect_grant(input int c);
    txn_t t;
    t.chn  = c;
    t.id   = ch_id[c];
    t.len  = ch_len[c];
    t.addr = ch_addr[c];
    ar_q.push_back(t);
    atx_q.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: pops an expected burst on every completed AR / txn-info handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_arvalid && bus.m_arready) begin
        if (ar_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ar_unexpected: got addr 0x%0h, expected no AR burst", bus.m_araddr);
        end else begin
          mon_ar = ar_q.pop_front();
          chk("ar_addr", 64'(bus.m_araddr), 64'(mon_ar.addr));
          chk("ar_len",  64'(bus.m_arlen),  64'(mon_ar.len));
          chk("ar_id",   64'(bus.m_arid),   64'(mon_ar.id));
        end
      end
      if (bus.atx_vld && bus.atx_rdy) begin
        if (atx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL atx_unexpected: got chn %0d, expected no txn info", bus.atx_chn_id);
        end else begin
          mon_atx = atx_q.pop_front();
          chk("atx_chn", 64'(bus.atx_chn_id), 64'(mon_atx.chn));
          chk("atx_id",  64'(bus.atx_arid),   64'(mon_atx.id));
          chk("atx_len", 64'(bus.atx_arlen),  64'(mon_atx.len));
        end
      end
    end
  end

  task automatic do_reset(input bit check);
    rst = 1'b1;
    bus.req_vld = '0;
    bus.m_arready = 1'b0;
    bus.atx_rdy = 1'b0;
    bus.rdone_vld = 1'b0;
    bus.rdone_chn_id = '0;
    ar_q.delete();
    atx_q.delete();
    cyc();
    bus.req_vld = '1;
    cyc();
    mid();
    if (check) begin
      chk("rst_req_rdy",   64'(bus.req_rdy),    64'h0);
      chk("rst_arvalid",   64'(bus.m_arvalid),  64'h0);
      chk("rst_atx_vld",   64'(bus.atx_vld),    64'h0);
      chk("rst_ostd",      64'(bus.ostd_cnt),   64'h0);
      chk("rst_araddr",    64'(bus.m_araddr),   64'h0);
      chk("rst_atx_chn",   64'(bus.atx_chn_id), 64'h0);
      chk("rst_arsize",    64'(bus.m_arsize),   64'h5);
      chk("rst_arburst",   64'(bus.m_arburst),  64'h1);
    end
    cyc();
    bus.req_vld = '0;
    rst = 1'b0;
  endtask

  // One channel, one handshake held off for three ISSUE cycles; afterwards a
  // request from c_next must be granted immediately, proving a return to IDLE.
  task automatic hs_case(input int c, input bit hold_ar, input int c_next);
    do_reset(1'b0);
    bus.req_vld   = oh(c);
    bus.m_arready = !hold_ar;
    bus.atx_rdy   = hold_ar;
    expect_grant(c);
    mid();
    chk("hs_grant", 64'(bus.req_rdy), 64'(oh(c)));
    cyc();
    bus.req_vld = '0;
    mid();
    chk("hs_c1_arvalid", 64'(bus.m_arvalid), 64'h1);
    chk("hs_c1_atx_vld", 64'(bus.atx_vld),   64'h1);
    for (int k = 2; k <= 3; k++) begin
      cyc();
      if (k == 3) begin
        if (hold_ar) bus.m_arready = 1'b1;
        else         bus.atx_rdy   = 1'b1;
      end
      mid();
      if (hold_ar) begin
        chk("hs_atx_dropped", 64'(bus.atx_vld),   64'h0);
        chk("hs_ar_held",     64'(bus.m_arvalid), 64'h1);
        chk("hs_ar_addr",     64'(bus.m_araddr),  64'(ch_addr[c]));
      end else begin
        chk("hs_ar_dropped",  64'(bus.m_arvalid),  64'h0);
        chk("hs_atx_held",    64'(bus.atx_vld),    64'h1);
        chk("hs_atx_chn",     64'(bus.atx_chn_id), 64'(c));
      end
    end
    cyc();
    bus.req_vld = oh(c_next);
    expect_grant(c_next);
    mid();
    chk("hs_done_arvalid", 64'(bus.m_arvalid), 64'h0);
    chk("hs_done_atx_vld", 64'(bus.atx_vld),   64'h0);
    chk("hs_idle_grant",   64'(bus.req_rdy),   64'(oh(c_next)));
    cyc();
    bus.req_vld = '0;
    mid();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      bus.req_addr[c*AW +: AW]   = ch_addr[c];
      bus.req_len[c*LW +: LW]    = ch_len[c];
      bus.chn_arid[c*IDW +: IDW] = ch_id[c];
    end

    // Single request on ch1
    do_reset(1'b1);
    bus.m_arready = 1'b1;
    bus.atx_rdy   = 1'b1;
    bus.req_vld   = 4'b0010;
    expect_grant(1);
    mid();
    chk("single_grant", 64'(bus.req_rdy), 64'h2);
    chk("single_ostd0", 64'(bus.ostd_cnt), 64'h0);
    cyc();
    bus.req_vld = '0;
    mid();
    chk("single_arvalid", 64'(bus.m_arvalid),  64'h1);
    chk("single_atx_vld", 64'(bus.atx_vld),    64'h1);
    chk("single_araddr",  64'(bus.m_araddr),   64'h1000);
    chk("single_arlen",   64'(bus.m_arlen),    64'h7);
    chk("single_atx_chn", 64'(bus.atx_chn_id), 64'h1);
    chk("single_ostd1",   64'(bus.ostd_cnt),   64'h1);
    chk("single_rdy_iss", 64'(bus.req_rdy),    64'h0);
    cyc();
    mid();
    chk("single_idle_arvalid", 64'(bus.m_arvalid), 64'h0);
    chk("single_idle_atx_vld", 64'(bus.atx_vld),   64'h0);
    cyc();

    // Round robin with all channels requesting, global limit 4
    do_reset(1'b0);
    bus.m_arready = 1'b1;
    bus.atx_rdy   = 1'b1;
    bus.req_vld   = 4'hF;
    for (int g = 0; g < N; g++) begin
      expect_grant(g);
      mid();
      chk("rr_grant", 64'(bus.req_rdy), 64'(oh(g)));
      cyc();
      mid();
      chk("rr_issue_no_grant", 64'(bus.req_rdy), 64'h0);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("rr_stall_rdy",  64'(bus.req_rdy),  64'h0);
      chk("rr_stall_ostd", 64'(bus.ostd_cnt), 64'h4);
      cyc();
    end
    bus.rdone_vld    = 1'b1;
    bus.rdone_chn_id = 2'd1;
    mid();
    chk("rr_rdone_same_cycle", 64'(bus.req_rdy), 64'h0);
    cyc();
    bus.rdone_vld = 1'b0;
    expect_grant(0);
    mid();
    chk("rr_after_rdone_grant", 64'(bus.req_rdy),  64'h1);
    chk("rr_after_rdone_ostd",  64'(bus.ostd_cnt), 64'h3);
    cyc();
    bus.req_vld = '0;
    mid();
    chk("rr_refill_ostd", 64'(bus.ostd_cnt), 64'h4);
    cyc();

    // Independent handshakes, both orders
    hs_case(1, 1'b1, 0);
    hs_case(2, 1'b0, 3);

    // Per-channel limit on ch2
    do_reset(1'b0);
    bus.m_arready = 1'b1;
    bus.atx_rdy   = 1'b1;
    bus.req_vld   = 4'b0100;
    for (int g = 0; g < 2; g++) begin
      expect_grant(2);
      mid();
      chk("chn_grant", 64'(bus.req_rdy), 64'h4);
      cyc();
      mid();
      cyc();
    end
    mid();
    chk("chn_limit_rdy",  64'(bus.req_rdy),  64'h0);
    chk("chn_limit_ostd", 64'(bus.ostd_cnt), 64'h2);
    cyc();
    bus.rdone_vld    = 1'b1;
    bus.rdone_chn_id = 2'd2;
    mid();
    chk("chn_rdone_same_cycle", 64'(bus.req_rdy), 64'h0);
    cyc();
    bus.rdone_vld = 1'b0;
    expect_grant(2);
    mid();
    chk("chn_third_grant", 64'(bus.req_rdy),  64'h4);
    chk("chn_third_ostd",  64'(bus.ostd_cnt), 64'h1);
    cyc();
    bus.req_vld = '0;
    mid();
    chk("chn_final_ostd", 64'(bus.ostd_cnt), 64'h2);
    cyc();

    // Simultaneous increment and decrement on ch0
    do_reset(1'b0);
    bus.m_arready = 1'b1;
    bus.atx_rdy   = 1'b1;
    bus.req_vld   = 4'b0001;
    expect_grant(0);
    mid();
    cyc();
    bus.req_vld = '0;
    mid();
    cyc();
    mid();
    chk("incdec_pre_ostd", 64'(bus.ostd_cnt), 64'h1);
    cyc();
    bus.req_vld      = 4'b0001;
    bus.rdone_vld    = 1'b1;
    bus.rdone_chn_id = 2'd0;
    expect_grant(0);
    mid();
    chk("incdec_grant", 64'(bus.req_rdy), 64'h1);
    cyc();
    bus.rdone_vld = 1'b0;
    mid();
    chk("incdec_ostd_same", 64'(bus.ostd_cnt), 64'h1);
    cyc();
    expect_grant(0);
    mid();
    chk("incdec_second_grant", 64'(bus.req_rdy), 64'h1);
    cyc();
    mid();
    chk("incdec_ostd2", 64'(bus.ostd_cnt), 64'h2);
    cyc();
    mid();
    chk("incdec_chn_full", 64'(bus.req_rdy), 64'h0);
    cyc();
    bus.req_vld = '0;
    cyc();

    // Reset while in ISSUE with both readies low
    do_reset(1'b0);
    bus.req_vld = 4'b1000;
    mid();
    chk("rstiss_grant", 64'(bus.req_rdy), 64'h8);
    cyc();
    bus.req_vld = '0;
    rst = 1'b1;
    mid();
    chk("rstiss_before", 64'(bus.m_arvalid), 64'h1);
    cyc();
    rst = 1'b0;
    mid();
    chk("rstiss_arvalid", 64'(bus.m_arvalid), 64'h0);
    chk("rstiss_atx_vld", 64'(bus.atx_vld),   64'h0);
    chk("rstiss_ostd",    64'(bus.ostd_cnt),  64'h0);
    chk("rstiss_rdy",     64'(bus.req_rdy),   64'h0);
    cyc();
    bus.req_vld   = 4'hF;
    bus.m_arready = 1'b1;
    bus.atx_rdy   = 1'b1;
    expect_grant(0);
    mid();
    chk("rstiss_restart_ch0", 64'(bus.req_rdy), 64'h1);
    cyc();
    bus.req_vld = '0;
    mid();
    cyc();
    cyc();

    mid();
    chk("ar_queue_drained",  64'(ar_q.size()),  64'h0);
    chk("atx_queue_drained", 64'(atx_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adma_dm_axi_ar_sched.md
Name: adma_dm_axi_ar_sched

Overview:
Read-side AR scheduler for the AXI DMA datamover. It round-robin arbitrates read-burst requests from DMA_CHN_NUM channels and drives the AXI AR channel. For every accepted burst it pushes {chn_id, arid, arlen} to the R-channel handler's transaction port, so the R handler can track order and route data. It enforces global and per-channel outstanding limits, and frees a slot when the R side reports a burst's last beat.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels (requesters)
MST_ID_W, 5, AXI ID width
ADDR_W, 32, AXI address width
ATX_LEN_W, 8, AxLEN width
ATX_SIZE_W, 3, AxSIZE width
ATX_SRC_DATA_W, 256, source data width; m_arsize = log2(ATX_SRC_DATA_W/8)
ATX_NUM_OSTD, DMA_CHN_NUM, max total outstanding read bursts
CHN_NUM_OSTD, 2, max outstanding read bursts per channel
DMA_CHN_NUM_W, (DMA_CHN_NUM>1)?$clog2(DMA_CHN_NUM):1, derived; do not set
OSTD_W, $clog2(ATX_NUM_OSTD+1), derived; do not set

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_vld  in  DMA_CHN_NUM  per-channel burst request valid
req_rdy  out  DMA_CHN_NUM  per-channel grant (one-hot or zero)
req_addr  in  DMA_CHN_NUM*ADDR_W  per-channel burst start address
req_len  in  DMA_CHN_NUM*ATX_LEN_W  per-channel AxLEN (beats-1)
chn_arid  in  DMA_CHN_NUM*MST_ID_W  per-channel AXI ID
m_arid  out  MST_ID_W  AR ID
m_araddr  out  ADDR_W  AR address
m_arlen  out  ATX_LEN_W  AR length
m_arsize  out  ATX_SIZE_W  AR size (constant)
m_arburst  out  2  AR burst, constant 2'b01 (INCR)
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
atx_chn_id  out  DMA_CHN_NUM_W  channel of issued burst, to R handler
atx_arid  out  MST_ID_W  ID of issued burst
atx_arlen  out  ATX_LEN_W  length of issued burst
atx_vld  out  1  transaction info valid
atx_rdy  in  1  R handler accepts info
rdone_vld  in  1  R handler accepted last beat of a burst
rdone_chn_id  in  DMA_CHN_NUM_W  channel of completed burst
ostd_cnt  out  OSTD_W  total outstanding bursts

Behaviour:
- Reset: state=IDLE. All outputs 0, except that m_arsize and m_arburst are held at their constant values. RR pointer=DMA_CHN_NUM-1. All counters=0.
- Eligible[i] = req_vld[i] & (chn_cnt[i] < CHN_NUM_OSTD) & (ostd_cnt < ATX_NUM_OSTD).
- IDLE: if any channel is eligible, grant the first eligible channel searching from ptr+1 upward with wrap.
  - req_rdy[g]=1 combinationally in that cycle only; the request handshake completes on req_vld & req_rdy.
  - Capture addr/len/arid/g into the issue register. ptr<=g. chn_cnt[g]++, ostd_cnt++. Go to ISSUE.
- ISSUE: m_arvalid=1 and atx_vld=1 from the registered values, so AR valid appears 1 cycle after the grant.
  - Each valid stays asserted with stable payload until its own handshake completes.
  - The two handshakes are independent; they may complete in either order or in the same cycle.
  - When both are done (including this cycle), go to IDLE. req_rdy=0 throughout ISSUE.
- Throughput is at most 1 burst per 2 cycles (IDLE→ISSUE→IDLE). No grant is made while in ISSUE.
- Completion: rdone_vld decrements chn_cnt[rdone_chn_id] and ostd_cnt.
  - Increment and decrement of the same counter in the same cycle leave it unchanged.
  - rdone_vld with a zero counter is ignored (saturate at 0) and is flagged by a sim-only assertion.
- The limit check uses the current counter values. A decrement in the same cycle does not make a channel eligible until the next cycle.
- Fairness: a continuously eligible channel is granted within DMA_CHN_NUM grants.
- Rising rst mid-ISSUE drops m_arvalid/atx_vld next cycle; counters are cleared. The system must not reset mid-burst on AXI unless the interconnect is reset too.

Test Plan:
- Single request: ch1 req_vld, addr=0x1000, len=7, arid=0x3, m_arready=atx_rdy=1. Expect req_rdy[1] in cycle 0; m_arvalid/atx_vld in cycle 1 with m_araddr=0x1000, m_arlen=7, atx_chn_id=1; ostd_cnt=1; IDLE in cycle 2.
- Round-robin: all 4 channels requesting continuously, no rdone, CHN_NUM_OSTD=2. Grant order 0,1,2,3. ostd_cnt stalls at 4 = ATX_NUM_OSTD and no grant follows until rdone_vld.
- Independent handshakes: atx_rdy=1 immediately, m_arready delayed 3 cycles. Expect atx_vld to drop after 1 cycle, m_arvalid held with stable payload for 3 cycles, then IDLE. Repeat with the delays swapped.
- Per-channel limit: only ch2 requesting, CHN_NUM_OSTD=2. Expect 2 grants, then req_rdy[2]=0. rdone_vld with chn 2 → third grant 1 cycle later.
- Simultaneous inc/dec: grant ch0 in the same cycle as rdone_vld for ch0 with chn_cnt[0]=1. Expect chn_cnt[0]=1 and ostd_cnt unchanged.
- Reset in ISSUE with m_arready=0: assert rst for 1 cycle. Expect m_arvalid=atx_vld=0, ostd_cnt=0, req_rdy=0 next cycle, then normal arbitration restarting at channel 0.
